bfly1_stage0: RTL and testbench

BFLY1_STAGE0 -- requirements
Module: bfly1_stage0

---
 rtl/bfly1_stage0.sv | 154 +++++++++++++++
 tb/tb_bfly1_stage0.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly1_stage0.sv
// First radix-2 butterfly stage: pairs each sample with the one HALF cycles later,
// emits sums immediately and the (optionally -j rotated) differences as a burst afterwards.
module bfly1_stage0 #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 12,
  parameter int NCHAN = 16,
  parameter int HALF  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [IN_W-1:0]  din_re [NCHAN],
  input  logic signed [IN_W-1:0]  din_im [NCHAN],
  input  logic                    din_valid,
  output logic signed [OUT_W-1:0] dout_re [NCHAN],
  output logic signed [OUT_W-1:0] dout_im [NCHAN],
  output logic                    dout_valid,
  output logic                    dout_sel
);

  localparam int PW = $clog2(HALF);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIFF = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          in_cnt;
  logic [PW-1:0]          rd_cnt;
  logic [PW-1:0]          p_idx;
  logic                   second_half;
  logic                   sec_accept;
  logic                   last_pair;
  logic                   rotate;

  logic signed [IN_W-1:0]  a_re [HALF][NCHAN];
  logic signed [IN_W-1:0]  a_im [HALF][NCHAN];
  logic signed [OUT_W-1:0] d_re [HALF][NCHAN];
  logic signed [OUT_W-1:0] d_im [HALF][NCHAN];

  logic signed [OUT_W-1:0] sum_re  [NCHAN];
  logic signed [OUT_W-1:0] sum_im  [NCHAN];
  logic signed [OUT_W-1:0] raw_re  [NCHAN];
  logic signed [OUT_W-1:0] raw_im  [NCHAN];
  logic signed [OUT_W-1:0] diff_re [NCHAN];
  logic signed [OUT_W-1:0] diff_im [NCHAN];

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return {{(OUT_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  assign second_half = in_cnt[CW-1];
  assign p_idx       = in_cnt[PW-1:0];
  assign sec_accept  = din_valid & second_half;
  assign last_pair   = (p_idx == PW'(HALF-1));
  assign rotate      = (p_idx >= PW'(HALF/2));

  // Exact butterfly per lane; upper-half pairs get the -j twiddle (re,im)->(im,-re)
  always_comb begin
    for (int l = 0; l < NCHAN; l++) begin
      sum_re[l] = sext(a_re[p_idx][l]) + sext(din_re[l]);
      sum_im[l] = sext(a_im[p_idx][l]) + sext(din_im[l]);
      raw_re[l] = sext(a_re[p_idx][l]) - sext(din_re[l]);
      raw_im[l] = sext(a_im[p_idx][l]) - sext(din_im[l]);
      if (rotate) begin
        diff_re[l] = raw_im[l];
        diff_im[l] = -raw_re[l];
      end else begin
        diff_re[l] = raw_re[l];
        diff_im[l] = raw_im[l];
      end
    end
  end

  // Accepted-cycle counter across a 2*HALF-cycle block
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt <= {CW{1'b0}};
    end else if (din_valid) begin
      if (in_cnt == CW'(2*HALF-1)) begin
        in_cnt <= {CW{1'b0}};
      end else begin
        in_cnt <= in_cnt + CW'(1);
      end
    end
  end

  // Sample buffers carry no reset: they are always written before being read
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < NCHAN; l++) begin
        if (!second_half) begin
          a_re[p_idx][l] <= din_re[l];
          a_im[p_idx][l] <= din_im[l];
        end else begin
          d_re[p_idx][l] <= diff_re[l];
          d_im[p_idx][l] <= diff_im[l];
        end
      end
    end
  end

  // Output sequencer: sums while pairing, then the stored diff burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rd_cnt     <= {PW{1'b0}};
      dout_valid <= 1'b0;
      dout_sel   <= 1'b0;
      for (int l = 0; l < NCHAN; l++) begin
        dout_re[l] <= {OUT_W{1'b0}};
        dout_im[l] <= {OUT_W{1'b0}};
      end
    end else begin
      case (state)
        IDLE, SUM: begin
          if (sec_accept) begin
            dout_valid <= 1'b1;
            dout_sel   <= 1'b0;
            for (int l = 0; l < NCHAN; l++) begin
              dout_re[l] <= sum_re[l];
              dout_im[l] <= sum_im[l];
            end
            state <= last_pair ? DIFF : SUM;
          end else begin
            dout_valid <= 1'b0;
          end
        end
        DIFF: begin
          dout_valid <= 1'b1;
          dout_sel   <= 1'b1;
          for (int l = 0; l < NCHAN; l++) begin
            dout_re[l] <= d_re[rd_cnt][l];
            dout_im[l] <= d_im[rd_cnt][l];
          end
          if (rd_cnt == PW'(HALF-1)) begin
            rd_cnt <= {PW{1'b0}};
            state  <= sec_accept ? SUM : IDLE;
          end else begin
            rd_cnt <= rd_cnt + PW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          rd_cnt     <= {PW{1'b0}};
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfly1_stage0.sv
// Self-checking bench for bfly1_stage0: a cycle-indexed expectation schedule built from
// plain integer butterfly arithmetic, checked every cycle plus directed value checks.
module tb_bfly1_stage0;

  localparam int IN_W  = 11;
  localparam int OUT_W = 12;
  localparam int NCHAN = 16;
  localparam int HALF  = 8;
  localparam int MAXC  = 512;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [IN_W-1:0]  din_re [NCHAN];
  logic signed [IN_W-1:0]  din_im [NCHAN];
  logic                    din_valid = 1'b0;
  logic signed [OUT_W-1:0] dout_re [NCHAN];
  logic signed [OUT_W-1:0] dout_im [NCHAN];
  logic                    dout_valid;
  logic                    dout_sel;

  always #5 clk = ~clk;

  bfly1_stage0 #(.IN_W(IN_W), .OUT_W(OUT_W), .NCHAN(NCHAN), .HALF(HALF)) dut (
    .clk(clk), .rstn(rstn),
    .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .dout_re(dout_re), .dout_im(dout_im), .dout_valid(dout_valid), .dout_sel(dout_sel)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc, mcnt, bad;
  int abr [HALF][NCHAN];
  int abi [HALF][NCHAN];
  int dbr [HALF][NCHAN];
  int dbi [HALF][NCHAN];
  bit ev [MAXC];
  bit es [MAXC];
  int er [MAXC][NCHAN];
  int ei [MAXC][NCHAN];
  int hr [NCHAN];
  int hi [NCHAN];

  task automatic model_reset();
    cyc = 0;
    mcnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      ev[c] = 1'b0;
      es[c] = 1'b0;
    end
    for (int l = 0; l < NCHAN; l++) begin
      hr[l] = 0;
      hi[l] = 0;
    end
  endtask

  task automatic rand_in();
    for (int l = 0; l < NCHAN; l++) begin
      din_re[l] = IN_W'($urandom);
      din_im[l] = IN_W'($urandom);
    end
  endtask

  // Drive one cycle and schedule what the output must show afterwards.
  task automatic step(input logic v);
    int p, br, bi, dr, di;
    din_valid = v;
    if (v) begin
      if (mcnt < HALF) begin
        for (int l = 0; l < NCHAN; l++) begin
          abr[mcnt][l] = int'(din_re[l]);
          abi[mcnt][l] = int'(din_im[l]);
        end
      end else begin
        p = mcnt - HALF;
        ev[cyc+1] = 1'b1;
        es[cyc+1] = 1'b0;
        for (int l = 0; l < NCHAN; l++) begin
          br = int'(din_re[l]);
          bi = int'(din_im[l]);
          er[cyc+1][l] = abr[p][l] + br;
          ei[cyc+1][l] = abi[p][l] + bi;
          dr = abr[p][l] - br;
          di = abi[p][l] - bi;
          if (p >= HALF/2) begin
            dbr[p][l] = di;
            dbi[p][l] = -dr;
          end else begin
            dbr[p][l] = dr;
            dbi[p][l] = di;
          end
        end
        if (p == HALF-1) begin
          for (int q = 0; q < HALF; q++) begin
            ev[cyc+2+q] = 1'b1;
            es[cyc+2+q] = 1'b1;
            for (int l = 0; l < NCHAN; l++) begin
              er[cyc+2+q][l] = dbr[q][l];
              ei[cyc+2+q][l] = dbi[q][l];
            end
          end
        end
      end
      mcnt = (mcnt + 1) % (2*HALF);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    din_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset dout_valid got=%b want=0", dout_valid); end
    n_chk++;
    if (dout_sel !== 1'b0) begin n_err++; $display("FAIL reset dout_sel got=%b want=0", dout_sel); end
    bad = 0;
    for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== 12'sd0 || dout_im[l] !== 12'sd0) bad++;
    n_chk++;
    if (bad != 0) begin n_err++; $display("FAIL reset lanes nonzero=%0d want=0", bad); end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 28; k++) begin
      rand_in();
      if (k < 16) begin
        din_re[0] = (k < HALF) ? 11'sd100 : 11'sd30;
        din_im[0] = 11'sd0;
      end
      step(k < 16);
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL basic valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL basic sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL basic lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
      if (cyc >= 9 && cyc <= 16) begin
        n_chk++;
        if (dout_re[0] !== 12'sd130 || dout_im[0] !== 12'sd0) begin n_err++; $display("FAIL basic sum130 cyc=%0d got=%0d,%0d want=130,0", cyc, dout_re[0], dout_im[0]); end
      end else if (cyc >= 17 && cyc <= 20) begin
        n_chk++;
        if (dout_re[0] !== 12'sd70 || dout_im[0] !== 12'sd0) begin n_err++; $display("FAIL basic diff70 cyc=%0d got=%0d,%0d want=70,0", cyc, dout_re[0], dout_im[0]); end
      end else if (cyc >= 21 && cyc <= 24) begin
        n_chk++;
        if (dout_re[0] !== 12'sd0 || dout_im[0] !== -12'sd70) begin n_err++; $display("FAIL basic rot70 cyc=%0d got=%0d,%0d want=0,-70", cyc, dout_re[0], dout_im[0]); end
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int k = 0; k < 28; k++) begin
      rand_in();
      if (k < 16) begin
        din_re[0] = (k < HALF) ? 11'h400 : 11'sd1023;
        din_im[0] = (k < HALF) ? 11'h400 : 11'sd1023;
      end
      step(k < 16);
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL extremes valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL extremes sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL extremes lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
      if (cyc >= 9 && cyc <= 16) begin
        n_chk++;
        if (dout_re[0] !== -12'sd1 || dout_im[0] !== -12'sd1) begin n_err++; $display("FAIL extremes sum cyc=%0d got=%0d,%0d want=-1,-1", cyc, dout_re[0], dout_im[0]); end
      end else if (cyc >= 17 && cyc <= 20) begin
        n_chk++;
        if (dout_re[0] !== -12'sd2047 || dout_im[0] !== -12'sd2047) begin n_err++; $display("FAIL extremes diff cyc=%0d got=%0d,%0d want=-2047,-2047", cyc, dout_re[0], dout_im[0]); end
      end else if (cyc >= 21 && cyc <= 24) begin
        n_chk++;
        if (dout_re[0] !== -12'sd2047 || dout_im[0] !== 12'sd2047) begin n_err++; $display("FAIL extremes rot cyc=%0d got=%0d,%0d want=-2047,2047", cyc, dout_re[0], dout_im[0]); end
      end
    end
  endtask

  task automatic test_stall();
    int lows;
    do_reset();
    lows = 0;
    for (int k = 0; k < 31; k++) begin
      rand_in();
      step((k < 12) || (k >= 15 && k < 19));
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL stall valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL stall sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL stall lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
      if (cyc >= 9 && cyc <= 27 && dout_valid !== 1'b1) lows++;
    end
    n_chk++;
    if (lows != 3) begin n_err++; $display("FAIL stall gap_len got=%0d want=3", lows); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 44; k++) begin
      rand_in();
      step(k < 32);
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL b2b valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL b2b sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL b2b lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      rand_in();
      step(1'b1);
    end
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid valid got=%b want=0", dout_valid); end
    bad = 0;
    for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== 12'sd0 || dout_im[l] !== 12'sd0) bad++;
    n_chk++;
    if (bad != 0) begin n_err++; $display("FAIL rstmid lanes nonzero=%0d want=0", bad); end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 28; k++) begin
      rand_in();
      step(k < 16);
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL rstmid post valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL rstmid post sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL rstmid post lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
    end
  endtask

  task automatic test_random();
    int acc;
    logic v;
    do_reset();
    acc = 0;
    for (int k = 0; k < 312; k++) begin
      rand_in();
      v = (acc < 64) && ($urandom_range(3) != 0);
      if (acc >= 64 && k >= 300) break;
      step(v);
      if (v) acc++;
      n_chk++;
      if (dout_valid !== ev[cyc]) begin n_err++; $display("FAIL random valid cyc=%0d got=%b want=%b", cyc, dout_valid, ev[cyc]); end
      if (ev[cyc]) begin
        n_chk++;
        if (dout_sel !== es[cyc]) begin n_err++; $display("FAIL random sel cyc=%0d got=%b want=%b", cyc, dout_sel, es[cyc]); end
        for (int l = 0; l < NCHAN; l++) begin hr[l] = er[cyc][l]; hi[l] = ei[cyc][l]; end
      end
      bad = 0;
      for (int l = 0; l < NCHAN; l++) if (dout_re[l] !== OUT_W'(hr[l]) || dout_im[l] !== OUT_W'(hi[l])) bad++;
      n_chk++;
      if (bad != 0) begin n_err++; $display("FAIL random lanes cyc=%0d bad=%0d lane0 got=%0d,%0d want=%0d,%0d", cyc, bad, dout_re[0], dout_im[0], hr[0], hi[0]); end
      if (acc >= 64 && cyc > 0 && !ev[cyc] && !ev[cyc+1] && mcnt == 0 && k > 80) break;
    end
    n_chk++;
    if (acc != 64) begin n_err++; $display("FAIL random accepts got=%0d want=64", acc); end
  endtask

  initial begin
    for (int l = 0; l < NCHAN; l++) begin
      din_re[l] = 11'sd0;
      din_im[l] = 11'sd0;
    end
    model_reset();
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
